// File: rtl/tug_key_conditioner.sv
`default_nettype none
// ============================================================================
// tug_key_conditioner: synchronise, debounce and pulse-shape L/R/S for the tug core
// Revision 1.0
// ============================================================================
module tug_key_conditioner #(
   parameter int unsigned DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic L_raw,
   input  logic R_raw,
   input  logic S_raw,
   output logic L,
   output logic R,
   output logic S,
   output logic tie
);

   localparam logic [1:0]  c_RELEASED     = 2'b00;
   localparam logic [1:0]  c_PRESS_WAIT   = 2'b01;
   localparam logic [1:0]  c_PRESSED      = 2'b10;
   localparam logic [1:0]  c_RELEASE_WAIT = 2'b11;
   localparam logic [15:0] c_LAST         = 16'(DEB_CYCLES - 1);
   // Entry count of 0 lets a single-cycle debounce commit on the first wait cycle
   localparam logic [15:0] c_FIRST        = (DEB_CYCLES == 1) ? 16'd0 : 16'd1;

   logic [2:0] w_raw;
   logic [2:0] r_sync1;
   logic [2:0] r_sync2;
   logic [2:0] w_press;

   assign w_raw = {S_raw, R_raw, L_raw};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 3'b000;
         r_sync2 <= 3'b000;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   generate
      for (genvar i = 0; i < 3; i++) begin : g_chan
         logic [1:0]  r_state;
         logic [1:0]  w_next;
         logic [15:0] r_cnt;
         logic [15:0] w_cnt_next;
         logic        w_s;

         assign w_s = r_sync2[i];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_state <= c_RELEASED;
               r_cnt   <= 16'd0;
            end else begin
               r_state <= w_next;
               r_cnt   <= w_cnt_next;
            end
         end

         always_comb begin
            w_next     = r_state;
            w_cnt_next = r_cnt;
            case (r_state)
               c_RELEASED: begin
                  if (w_s) begin
                     w_next     = c_PRESS_WAIT;
                     w_cnt_next = c_FIRST;
                  end
               end
               c_PRESS_WAIT: begin
                  if (!w_s) begin
                     w_next     = c_RELEASED;
                     w_cnt_next = 16'd0;
                  end else if (r_cnt == c_LAST) begin
                     w_next     = c_PRESSED;
                     w_cnt_next = 16'd0;
                  end else begin
                     w_cnt_next = r_cnt + 16'd1;
                  end
               end
               c_PRESSED: begin
                  if (!w_s) begin
                     w_next     = c_RELEASE_WAIT;
                     w_cnt_next = c_FIRST;
                  end
               end
               default: begin
                  if (w_s) begin
                     w_next     = c_PRESSED;
                     w_cnt_next = 16'd0;
                  end else if (r_cnt == c_LAST) begin
                     w_next     = c_RELEASED;
                     w_cnt_next = 16'd0;
                  end else begin
                     w_cnt_next = r_cnt + 16'd1;
                  end
               end
            endcase
         end

         always_comb begin
            w_press[i] = (r_state == c_PRESS_WAIT) && w_s && (r_cnt == c_LAST);
         end

         // The debounced switch level is the "pressed side" bit of the state code
         if (i == 2) begin : g_level
            assign S = r_state[1];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         L   <= 1'b0;
         R   <= 1'b0;
         tie <= 1'b0;
      end else begin
         L   <= en & w_press[0] & ~w_press[1];
         R   <= en & w_press[1] & ~w_press[0];
         tie <= en & w_press[0] &  w_press[1];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tug_key_conditioner.sv
`default_nettype none
// ============================================================================
// tb_tug_key_conditioner: randomized + directed scoreboard bench for the key conditioner
// Revision 1.0
// ============================================================================
module tb_tug_key_conditioner;

   localparam int DEB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic L_raw = 1'b0, R_raw = 1'b0, S_raw = 1'b0;
   logic L, R, S, tie;

   int tests = 0;
   int fails = 0;
   int cycle = 0;
   int l_seen = 0, r_seen = 0, tie_seen = 0;

   tug_key_conditioner #(.DEB_CYCLES(DEB)) dut (
      .clk(clk), .rst(rst), .en(en),
      .L_raw(L_raw), .R_raw(R_raw), .S_raw(S_raw),
      .L(L), .R(R), .S(S), .tie(tie)
   );

   always #5 clk = ~clk;

   // Reference: a key commits once DEB consecutive synchronized samples disagree
   // with its committed level; samples are the raw inputs seen two edges earlier.
   logic [3:0] exp_q[$];
   logic [2:0] d1 = 3'b000, d2 = 3'b000, lvl = 3'b000, press;
   int         run [3];
   logic [3:0] exp_v;

   always @(posedge clk) begin
      cycle++;
      if (rst) begin
         d1 = 3'b000;
         d2 = 3'b000;
         lvl = 3'b000;
         for (int c = 0; c < 3; c++) run[c] = 0;
         exp_v = 4'b0000;
      end else begin
         press = 3'b000;
         for (int c = 0; c < 3; c++) begin
            if (d2[c] != lvl[c]) begin
               run[c] = run[c] + 1;
               if (run[c] == DEB) begin
                  lvl[c]   = d2[c];
                  run[c]   = 0;
                  press[c] = d2[c];
               end
            end else begin
               run[c] = 0;
            end
         end
         d2 = d1;
         d1 = {S_raw, R_raw, L_raw};
         exp_v = {en & press[0] & ~press[1], en & press[1] & ~press[0],
                  lvl[2], en & press[0] & press[1]};
      end
      exp_q.push_back(exp_v);
   end

   // Monitor: one expected vector per cycle, compared mid-cycle
   always @(negedge clk) begin
      logic [3:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rst) e = 4'b0000;
         tests++;
         if ({L, R, S, tie} !== e) begin
            fails++;
            $display("FAIL scoreboard cycle %0d {L,R,S,tie}: got %b want %b",
                     cycle, {L, R, S, tie}, e);
         end
         if (L === 1'b1) l_seen++;
         if (R === 1'b1) r_seen++;
         if (tie === 1'b1) tie_seen++;
      end
   end

   task automatic check(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic drive(input logic l, input logic r, input logic s, input logic e, input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #2;
         L_raw = l; R_raw = r; S_raw = s; en = e;
      end
   endtask

   task automatic clear_counts();
      @(posedge clk);
      #1;
      l_seen = 0; r_seen = 0; tie_seen = 0;
   endtask

   initial begin
      logic [2:0] cur;
      int         left [3];
      logic       ev;

      repeat (3) @(posedge clk);
      #2;
      check("reset_outputs", int'({L, R, S, tie}), 0);
      rst = 1'b0;

      // Left press held 20 cycles
      clear_counts();
      drive(1, 0, 0, 1, 20);
      drive(0, 0, 0, 1, 12);
      check("held_L_pulses", l_seen, 1);
      check("held_R_pulses", r_seen, 0);
      check("held_tie_pulses", tie_seen, 0);

      // Short glitch on left
      clear_counts();
      drive(1, 0, 0, 1, 3);
      drive(0, 0, 0, 1, 12);
      check("glitch_L_pulses", l_seen, 0);

      // Simultaneous left/right presses
      clear_counts();
      drive(1, 1, 0, 1, 20);
      drive(0, 0, 0, 1, 12);
      check("tie_pulses", tie_seen, 1);
      check("tie_L_pulses", l_seen, 0);
      check("tie_R_pulses", r_seen, 0);

      // Press committed while disabled is discarded
      clear_counts();
      drive(1, 0, 0, 0, 10);
      drive(1, 0, 0, 1, 10);
      drive(0, 0, 0, 1, 12);
      check("disabled_L_pulses", l_seen, 0);
      drive(1, 0, 0, 1, 12);
      drive(0, 0, 0, 1, 12);
      check("reenabled_L_pulses", l_seen, 1);

      // Start switch with a short low glitch, then a real release
      drive(0, 0, 1, 1, 10);
      check("S_on", int'(S), 1);
      drive(0, 0, 0, 1, 2);
      drive(0, 0, 1, 1, 6);
      check("S_glitch_hold", int'(S), 1);
      drive(0, 0, 0, 1, 10);
      check("S_off", int'(S), 0);

      // Reset mid-debounce, key held through reset release
      clear_counts();
      drive(1, 0, 1, 1, 4);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_outputs", int'({L, R, S, tie}), 0);
      drive(1, 0, 1, 1, 2);
      rst = 1'b0;
      drive(1, 0, 1, 1, 12);
      check("post_reset_L_pulses", l_seen, 1);
      check("post_reset_S", int'(S), 1);
      drive(0, 0, 0, 1, 12);

      // Randomized run-length stimulus
      cur = 3'b000;
      for (int c = 0; c < 3; c++) left[c] = 0;
      for (int k = 0; k < 3000; k++) begin
         for (int c = 0; c < 3; c++) begin
            if (left[c] == 0) begin
               cur[c]  = ~cur[c];
               left[c] = int'($urandom_range(1, 8));
            end
            left[c]--;
         end
         ev = ($urandom_range(0, 9) != 0);
         @(posedge clk);
         #2;
         L_raw = cur[0]; R_raw = cur[1]; S_raw = cur[2]; en = ev;
         rst = ($urandom_range(0, 399) == 0);
      end
      rst = 1'b0;
      drive(0, 0, 0, 1, 12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
